// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: register offsets, CTRL bit positions,
// read-mux select encoding and the FIFO level formatting helper.
package mmio_pkg;

    localparam logic [31:0] OFF_CTRL       = 32'h0000_0000;
    localparam logic [31:0] OFF_RX_DATA    = 32'h0000_0004;
    localparam logic [31:0] OFF_TX_DATA    = 32'h0000_0008;
    localparam logic [31:0] OFF_FIFO_LEVEL = 32'h0000_000C;
    localparam logic [31:0] OFF_CYCLE_CNT  = 32'h0000_0010;
    localparam logic [31:0] OFF_INST_CNT   = 32'h0000_0014;
    localparam logic [31:0] OFF_CNT_RST    = 32'h0000_0018;
    localparam logic [31:0] OFF_FLAG_CLR   = 32'h0000_001C;

    // FLAG_CLR uses the same bit positions as the sticky bits in CTRL
    localparam int CTRL_TX_NFULL  = 0;
    localparam int CTRL_RX_NEMPTY = 1;
    localparam int CTRL_RX_OVF    = 2;
    localparam int CTRL_TX_OVF    = 3;

    typedef enum logic [2:0] {
        SEL_CTRL  = 3'd0,
        SEL_RX    = 3'd1,
        SEL_LEVEL = 3'd2,
        SEL_CYC   = 3'd3,
        SEL_INST  = 3'd4,
        SEL_NONE  = 3'd5
    } rd_sel_e;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        logic [7:0] r;
        if (v > 32'd255) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// First-word-fall-through FIFO: head shows the oldest entry while not empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // full/empty derive from the registered count only
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// MMIO window between the execute stage and the UART: RX/TX byte FIFOs,
// cycle/instruction counters, sticky overflow flags and a registered read port.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic        rdata_hit,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam int TX_CW = $clog2(TX_DEPTH + 1);

    localparam logic [31:0] ADDR_CTRL       = BASE_ADDR + OFF_CTRL;
    localparam logic [31:0] ADDR_RX_DATA    = BASE_ADDR + OFF_RX_DATA;
    localparam logic [31:0] ADDR_TX_DATA    = BASE_ADDR + OFF_TX_DATA;
    localparam logic [31:0] ADDR_FIFO_LEVEL = BASE_ADDR + OFF_FIFO_LEVEL;
    localparam logic [31:0] ADDR_CYCLE_CNT  = BASE_ADDR + OFF_CYCLE_CNT;
    localparam logic [31:0] ADDR_INST_CNT   = BASE_ADDR + OFF_INST_CNT;
    localparam logic [31:0] ADDR_CNT_RST    = BASE_ADDR + OFF_CNT_RST;
    localparam logic [31:0] ADDR_FLAG_CLR   = BASE_ADDR + OFF_FLAG_CLR;

    rd_sel_e              sel_s;
    logic                 rd_hit_s;
    logic                 tx_store_s;
    logic                 cnt_srst_s;
    logic                 flag_clr_s;
    logic                 rx_pop_s;
    logic                 rx_ovf_set_s;
    logic                 tx_ovf_set_s;
    logic [31:0]          ctrl_s;
    logic [31:0]          rd_val_s;
    logic                 rx_full_s;
    logic                 rx_empty_s;
    logic [RX_CW-1:0]     rx_count_s;
    logic [7:0]           rx_head_s;
    logic                 tx_full_s;
    logic                 tx_empty_s;
    logic [TX_CW-1:0]     tx_count_s;
    logic [CNT_WIDTH-1:0] cyc_r;
    logic [CNT_WIDTH-1:0] inst_r;
    logic                 rx_ovf_r;
    logic                 tx_ovf_r;
    logic                 unused_wdata_s;

    assign unused_wdata_s = ^req_wdata[31:8];

    mmio_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_rx_valid),
        .wdata (uart_rx_data),
        .pop   (rx_pop_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s),
        .head  (rx_head_s)
    );

    mmio_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_store_s),
        .wdata (req_wdata[7:0]),
        .pop   (uart_tx_ready),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s),
        .head  (uart_tx_data)
    );

    // ready reflects the full flag before any same-cycle pop
    assign uart_rx_ready = !rx_full_s;
    assign uart_tx_valid = !tx_empty_s;
    assign rx_pop_s      = (sel_s == SEL_RX) && !rx_empty_s;
    assign rx_ovf_set_s  = uart_rx_valid && rx_full_s;
    assign tx_ovf_set_s  = tx_store_s && tx_full_s;

    // exact-address decode of loads and stores
    always_comb begin
        sel_s      = SEL_NONE;
        rd_hit_s   = 1'b0;
        tx_store_s = 1'b0;
        cnt_srst_s = 1'b0;
        flag_clr_s = 1'b0;
        if (req_valid && !req_we) begin
            case (req_addr)
                ADDR_CTRL:       begin sel_s = SEL_CTRL;  rd_hit_s = 1'b1; end
                ADDR_RX_DATA:    begin sel_s = SEL_RX;    rd_hit_s = 1'b1; end
                ADDR_FIFO_LEVEL: begin sel_s = SEL_LEVEL; rd_hit_s = 1'b1; end
                ADDR_CYCLE_CNT:  begin sel_s = SEL_CYC;   rd_hit_s = 1'b1; end
                ADDR_INST_CNT:   begin sel_s = SEL_INST;  rd_hit_s = 1'b1; end
                default:         begin sel_s = SEL_NONE;  rd_hit_s = 1'b0; end
            endcase
        end else if (req_valid && req_we) begin
            case (req_addr)
                ADDR_TX_DATA:  tx_store_s = 1'b1;
                ADDR_CNT_RST:  cnt_srst_s = 1'b1;
                ADDR_FLAG_CLR: flag_clr_s = 1'b1;
                default:       tx_store_s = 1'b0;
            endcase
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // read data selection from pre-edge state
    always_comb begin
        ctrl_s                 = 32'd0;
        ctrl_s[CTRL_TX_NFULL]  = !tx_full_s;
        ctrl_s[CTRL_RX_NEMPTY] = !rx_empty_s;
        ctrl_s[CTRL_RX_OVF]    = rx_ovf_r;
        ctrl_s[CTRL_TX_OVF]    = tx_ovf_r;
        case (sel_s)
            SEL_CTRL:  rd_val_s = ctrl_s;
            SEL_RX:    rd_val_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
            SEL_LEVEL: rd_val_s = {16'd0, sat8(32'(tx_count_s)), sat8(32'(rx_count_s))};
            SEL_CYC:   rd_val_s = 32'(cyc_r);
            SEL_INST:  rd_val_s = 32'(inst_r);
            default:   rd_val_s = 32'd0;
        endcase
    end

    // registered read port, rdata held across non-hit cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= 32'd0;
            rdata_hit <= 1'b0;
        end else begin
            rdata_hit <= rd_hit_s;
            if (rd_hit_s) begin
                rdata <= rd_val_s;
            end else begin
                rdata <= rdata;
            end
        end
    end

    // free-running counters; a CNT_RST write acts as their synchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r  <= {CNT_WIDTH{1'b0}};
            inst_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_srst_s) begin
            cyc_r  <= {CNT_WIDTH{1'b0}};
            inst_r <= {CNT_WIDTH{1'b0}};
        end else begin
            cyc_r <= cyc_r + CNT_WIDTH'(1);
            if (inst_retire) begin
                inst_r <= inst_r + CNT_WIDTH'(1);
            end else begin
                inst_r <= inst_r;
            end
        end
    end

    // sticky overflow flags, a new overflow beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf_r <= 1'b0;
            tx_ovf_r <= 1'b0;
        end else begin
            rx_ovf_r <= rx_ovf_set_s | (rx_ovf_r & ~(flag_clr_s & req_wdata[CTRL_RX_OVF]));
            tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~(flag_clr_s & req_wdata[CTRL_TX_OVF]));
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random phase.
module tb_mmio_hub;

    localparam int RXD  = 4;
    localparam int TXD  = 8;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    localparam logic [31:0] A_CTRL  = 32'h8000_0000;
    localparam logic [31:0] A_RX    = 32'h8000_0004;
    localparam logic [31:0] A_TX    = 32'h8000_0008;
    localparam logic [31:0] A_LEVEL = 32'h8000_000C;
    localparam logic [31:0] A_CYC   = 32'h8000_0010;
    localparam logic [31:0] A_INST  = 32'h8000_0014;
    localparam logic [31:0] A_CRST  = 32'h8000_0018;
    localparam logic [31:0] A_FCLR  = 32'h8000_001C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        inst_retire = 1'b0;
    logic [31:0] rdata;
    logic        rdata_hit;
    logic [7:0]  uart_rx_data = 8'd0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;

    always #5 clk = ~clk;

    mmio_hub #(
        .BASE_ADDR (32'h8000_0000),
        .RX_DEPTH  (RXD),
        .TX_DEPTH  (TXD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .inst_retire   (inst_retire),
        .rdata         (rdata),
        .rdata_hit     (rdata_hit),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    int total = 0;
    int bad = 0;

    // reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int unsigned m_cyc;
    int unsigned m_inst;
    bit          m_rovf;
    bit          m_tovf;
    logic [31:0] m_rdata;
    bit          m_hit;
    bit          m_known;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_cyc   = 0;
        m_inst  = 0;
        m_rovf  = 1'b0;
        m_tovf  = 1'b0;
        m_rdata = 32'd0;
        m_hit   = 1'b0;
        m_known = 1'b1;
    endtask

    // one clock edge: predict from pre-edge inputs/state, then commit
    task automatic step();
        logic        v, we, ret, rxv, txr;
        logic [31:0] a, wd, val;
        logic [7:0]  rxb;
        bit hit, rpop, rpush, rset, tpop, tpush, tset, cclr, fclr;
        v = req_valid; we = req_we; a = req_addr; wd = req_wdata;
        ret = inst_retire; rxv = uart_rx_valid; rxb = uart_rx_data; txr = uart_tx_ready;
        hit = 0; val = 32'd0; rpop = 0; tpush = 0; tset = 0; cclr = 0; fclr = 0;
        if (v && !we) begin
            case (a)
                A_CTRL: begin
                    hit = 1;
                    val = {28'd0, m_tovf, m_rovf, (rxq.size() != 0), (txq.size() != TXD)};
                end
                A_RX: begin
                    hit = 1;
                    if (rxq.size() != 0) begin
                        val  = {24'd0, rxq[0]};
                        rpop = 1;
                    end
                end
                A_LEVEL: begin
                    hit = 1;
                    val = 32'(rxq.size()) | (32'(txq.size()) << 8);
                end
                A_CYC:   begin hit = 1; val = 32'(m_cyc);  end
                A_INST:  begin hit = 1; val = 32'(m_inst); end
                default: hit = 0;
            endcase
        end else if (v && we) begin
            case (a)
                A_TX: begin
                    if (txq.size() == TXD) tset = 1;
                    else tpush = 1;
                end
                A_CRST:  cclr = 1;
                A_FCLR:  fclr = 1;
                default: ;
            endcase
        end
        rset  = rxv && (rxq.size() == RXD);
        rpush = rxv && !rset;
        tpop  = txr && (txq.size() != 0);
        @(posedge clk);
        #1;
        if (rpop)  void'(rxq.pop_front());
        if (rpush) rxq.push_back(rxb);
        if (tpop)  void'(txq.pop_front());
        if (tpush) txq.push_back(wd[7:0]);
        m_rovf = rset || (m_rovf && !(fclr && wd[2]));
        m_tovf = tset || (m_tovf && !(fclr && wd[3]));
        if (cclr) begin
            m_cyc  = 0;
            m_inst = 0;
        end else begin
            m_cyc = (m_cyc + 1) % CMOD;
            if (ret) m_inst = (m_inst + 1) % CMOD;
        end
        m_hit = hit;
        if (hit) begin
            m_rdata = val;
            m_known = 1'b1;
        end else if (v) begin
            m_known = 1'b0;
        end
    endtask

    task automatic ld(input logic [31:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    // per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata_hit", {31'd0, rdata_hit}, {31'd0, m_hit});
            if (m_known) check("rdata", rdata, m_rdata);
            check("rx_ready", {31'd0, uart_rx_ready}, {31'd0, (rxq.size() < RXD)});
            check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, (txq.size() != 0)});
            if (txq.size() != 0) check("tx_data", {24'd0, uart_tx_data}, {24'd0, txq[0]});
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // CTRL after reset
        ld(A_CTRL);
        check("reset_ctrl", rdata, 32'h0000_0001);
        check("reset_ctrl_hit", {31'd0, rdata_hit}, 32'd1);

        // RX basic: two bytes, then read past empty
        uart_rx_valid = 1'b1; uart_rx_data = 8'h41; step();
        uart_rx_data = 8'h42; step();
        uart_rx_valid = 1'b0;
        ld(A_LEVEL); check("rx_level2", rdata, 32'd2);
        ld(A_RX);    check("rx_byte0", rdata, 32'h41);
        ld(A_LEVEL); check("rx_level1", rdata, 32'd1);
        ld(A_RX);    check("rx_byte1", rdata, 32'h42);
        ld(A_LEVEL); check("rx_level0", rdata, 32'd0);
        ld(A_RX);    check("rx_empty_read", rdata, 32'd0);
        check("rx_empty_hit", {31'd0, rdata_hit}, 32'd1);

        // TX fill with transmitter stalled, ninth store overflows
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) st(A_TX, 32'(i));
        ld(A_CTRL);  check("tx_full_ctrl", rdata, 32'h0000_0008);
        ld(A_LEVEL); check("tx_full_level", rdata, 32'h0000_0800);
        uart_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("tx_order", {24'd0, uart_tx_data}, 32'(i));
            step();
        end
        check("tx_drained", {31'd0, uart_tx_valid}, 32'd0);
        uart_tx_ready = 1'b0;
        st(A_FCLR, 32'h8);
        ld(A_CTRL);  check("tx_ovf_cleared", rdata, 32'h0000_0001);

        // RX overflow while popping, W1C clear, set-wins-over-clear
        uart_rx_valid = 1'b1;
        for (int i = 0; i < RXD; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            step();
        end
        check("rx_full_ready", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_data = 8'h55;
        ld(A_RX);    check("rx_pop_full", rdata, 32'h10);
        uart_rx_valid = 1'b0;
        ld(A_LEVEL); check("rx_level_after_drop", rdata, 32'd3);
        ld(A_CTRL);  check("rx_ovf_ctrl", rdata, 32'h0000_0007);
        st(A_FCLR, 32'h4);
        ld(A_CTRL);  check("rx_ovf_cleared", rdata, 32'h0000_0003);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h66; step();
        uart_rx_data = 8'h77;
        st(A_FCLR, 32'h4);
        uart_rx_valid = 1'b0;
        ld(A_CTRL);  check("set_wins", rdata, 32'h0000_0007);
        ld(A_RX);    check("rx_seq0", rdata, 32'h11);
        ld(A_RX);    check("rx_seq1", rdata, 32'h12);
        ld(A_RX);    check("rx_seq2", rdata, 32'h13);
        ld(A_RX);    check("rx_seq3", rdata, 32'h66);
        st(A_FCLR, 32'hC);

        // counters: wrap and reset-beats-increment
        st(A_CRST, 32'd0);
        repeat (17) step();
        ld(A_CYC);   check("cyc_wrap", rdata, 32'd1);
        inst_retire = 1'b1;
        st(A_CRST, 32'd0);
        inst_retire = 1'b0;
        ld(A_INST);  check("inst_rst_wins", rdata, 32'd0);
        inst_retire = 1'b1;
        repeat (3) step();
        inst_retire = 1'b0;
        ld(A_INST);  check("inst_count3", rdata, 32'd3);

        // asynchronous reset during a TX drain
        st(A_TX, 32'hA1); st(A_TX, 32'hA2); st(A_TX, 32'hA3);
        uart_tx_ready = 1'b1;
        step();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_hit", {31'd0, rdata_hit}, 32'd0);
        check("arst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        uart_tx_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        ld(A_LEVEL); check("arst_level", rdata, 32'd0);
        ld(A_CYC);   check("arst_cyc", rdata, 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            if (r < 8)       req_addr = 32'h8000_0000 + 32'(r * 4);
            else if (r == 8) req_addr = 32'h8000_0020;
            else             req_addr = 32'h8000_0002;
            req_wdata     = $urandom;
            inst_retire   = ($urandom_range(0, 1) == 1);
            uart_rx_valid = ($urandom_range(0, 9) < 6);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 9) < 4);
            step();
        end
        req_valid = 1'b0;
        uart_rx_valid = 1'b0;
        inst_retire = 1'b0;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Parametrised memory-mapped I/O block between the CPU execute stage and the UART.
- Decodes load/store requests in the MMIO window at BASE_ADDR.
- Buffers UART RX/TX bytes in FIFOs of configurable depth, and keeps cycle/retired-instruction counters of configurable width.
- Returns read data one cycle after the request, aligned with MEM/WB, and adds overflow tracking and FIFO occupancy reporting.

Parameters:
- BASE_ADDR, 32'h80000000, base of the MMIO window; register offsets are added to it.
- RX_DEPTH, 8, RX FIFO entries; power of two, ≥2.
- TX_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- CNT_WIDTH, 32, counter width, 1..32; zero-extended on read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU memory access in EX this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data
- inst_retire  in  1  one instruction retired this cycle
- rdata  out  32  registered read data
- rdata_hit  out  1  registered; previous-cycle load hit a readable MMIO register
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  receiver byte valid
- uart_rx_ready  out  1  hub accepts RX byte
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts byte

Behaviour:
- Register map (offset, access):
  - 0x00 CTRL, RO: bit0 = TX not full, bit1 = RX not empty, bit2 = rx_ovf sticky, bit3 = tx_ovf sticky.
  - 0x04 RX_DATA, RO, pops: read value {24'b0, head}.
  - 0x08 TX_DATA, WO, pushes req_wdata[7:0].
  - 0x0C FIFO_LEVEL, RO: [7:0] = RX count, [15:8] = TX count.
  - 0x10 CYCLE_CNT, RO.
  - 0x14 INST_CNT, RO.
  - 0x18 CNT_RST, WO: any write clears both counters.
  - 0x1C FLAG_CLR, WO: write-1-to-clear wdata[2] → rx_ovf, wdata[3] → tx_ovf.
- Address match is exact 32-bit. Any other address is a miss: no side effect, rdata_hit = 0 next cycle.
- Load to a WO offset, or store to an RO offset: no side effect; rdata_hit = 0 for WO loads.
- Read latency: load hit at cycle N → rdata/rdata_hit valid at cycle N+1 and held until the next request. A non-request cycle clears rdata_hit but keeps rdata.
- RX pop happens at the load's cycle edge, so the next RX_DATA read sees the next byte.
- RX_DATA read when empty: returns 0, no pop, rdata_hit = 1.
- RX push:
  - uart_rx_ready = !rx_full, from registered state only; no combinational path from req_*.
  - Push when rx_valid && rx_ready.
  - If rx_valid while full: byte dropped, rx_ovf set.
- TX:
  - Store to TX_DATA when not full pushes.
  - Store when full: dropped, tx_ovf set.
  - uart_tx_valid = !tx_empty; uart_tx_data = head, stable while valid && !ready.
  - Pop on tx_valid && tx_ready.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count unchanged.
  - When full, the RX push is still refused, because ready is computed from the full flag before the pop.
- Counters:
  - CYCLE_CNT increments every cycle.
  - INST_CNT increments when inst_retire.
  - Both wrap from 2^CNT_WIDTH−1 to 0.
  - A CNT_RST write wins over increment: both read 0 the following cycle, then resume counting.
- Flags: a FLAG_CLR write in the same cycle as a new overflow leaves the flag set (set wins).
- Reset: rst_n low asynchronously clears FIFOs (empty), pointers, counters, flags, rdata = 0, rdata_hit = 0.
  - Outputs during reset: uart_rx_ready = 1, uart_tx_valid = 0.
  - A mid-transfer TX byte is discarded.
- Widths: FIFO count is $clog2(DEPTH+1) bits, zero-extended into its 8-bit field, saturating the field at 255.

Decomposition:
- mmio_pkg holds:
  - register offset localparams (OFF_CTRL … OFF_FLAG_CLR);
  - CTRL bit-index constants;
  - the read-mux select enum (SEL_CTRL, SEL_RX, SEL_LEVEL, SEL_CYC, SEL_INST, SEL_NONE).
- Sub-module mmio_fifo (params WIDTH, DEPTH) provides:
  - push/pop, full, empty, count, head outputs;
  - first-word-fall-through behaviour;
  - instantiation once for RX (8-bit) and once for TX (8-bit).
- Decode, counters, flags and the registered read mux live in mmio_hub.

Test Plan:
- Reset then load 0x80000000 → next cycle rdata = 0x00000001 (TX not full, RX empty, no flags), rdata_hit = 1.
- Push RX bytes 0x41, 0x42 → two RX_DATA loads return 0x41 then 0x42; third returns 0 with no pop; FIFO_LEVEL[7:0] goes 2→1→0.
- Hold uart_tx_ready = 0, store TX_DATA 9 times with DEPTH = 8 → 8 bytes buffered, CTRL bit3 = 1, bit0 = 0. Release ready → bytes leave in order, 1 per cycle.
- CNT_WIDTH = 4, run 17 cycles → CYCLE_CNT reads 1 after wrap. CNT_RST write concurrent with inst_retire → INST_CNT = 0 next cycle.
- Full RX FIFO with simultaneous rx_valid and RX_DATA pop → incoming byte dropped, rx_ovf set, count becomes DEPTH−1. FLAG_CLR wdata = 0x4 → bit2 cleared.
- Assert rst_n low mid TX drain (tx_valid = 1) → same cycle tx_valid = 0, rdata = 0, counters 0, FIFO_LEVEL = 0 after release.
